// File: rtl/instr_encoder.sv
// instr_encoder
// Streaming RV32I instruction encoder. Takes one field bundle per in_valid/
// in_ready handshake and packs it into a 32-bit RV32I word (R/I/S/B/U/J
// layouts). Each word leaves through a one-entry output register tagged with
// an incrementing instruction-memory word address.
//
// Ports:
//   clk, rst           clock (rising edge), asynchronous active-high reset
//   start              begin a program (only honoured in IDLE)
//   in_valid/in_ready  input bundle handshake
//   type_sel           0 R, 1 I-load, 2 I-ALU, 3 S, 4 B, 5 AUIPC, 6 LUI,
//                      7 JALR, 8 JAL; 9..15 illegal
//   funct3, funct7     function fields
//   rd, rs1, rs2       register indices
//   imm                immediate, interpreted per type
//   in_last            final bundle of the program
//   out_valid/out_ready output word handshake
//   out_instr          encoded instruction
//   out_addr           word address of out_instr
//   out_last           word is the last of the program
//   out_count          words transferred since start (saturating)
//   done               one-cycle pulse at program completion
//   err                sticky: illegal type_sel seen since start
module instr_encoder #(
  parameter int                    ADDR_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            type_sel,
  input  logic [2:0]            funct3,
  input  logic [6:0]            funct7,
  input  logic [4:0]            rd,
  input  logic [4:0]            rs1,
  input  logic [4:0]            rs2,
  input  logic [31:0]           imm,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_instr,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  out_last,
  output logic [ADDR_WIDTH:0]   out_count,
  output logic                  done,
  output logic                  err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [3:0] T_R     = 4'd0;
  localparam logic [3:0] T_LOAD  = 4'd1;
  localparam logic [3:0] T_IALU  = 4'd2;
  localparam logic [3:0] T_S     = 4'd3;
  localparam logic [3:0] T_B     = 4'd4;
  localparam logic [3:0] T_AUIPC = 4'd5;
  localparam logic [3:0] T_LUI   = 4'd6;
  localparam logic [3:0] T_JALR  = 4'd7;
  localparam logic [3:0] T_JAL   = 4'd8;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_IALU  = 7'b0010011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   CNT_MAX  = {(ADDR_WIDTH+1){1'b1}};

  // Packs one bundle into its RV32I layout; illegal types yield zero (the
  // word is dropped anyway).
  function automatic logic [31:0] encode_word(
    input logic [3:0]  t,
    input logic [2:0]  f3,
    input logic [6:0]  f7,
    input logic [4:0]  d,
    input logic [4:0]  s1,
    input logic [4:0]  s2,
    input logic [31:0] im
  );
    logic [31:0] w;
    w = 32'd0;
    case (t)
      T_R:     w = {f7, s2, s1, f3, d, OP_R};
      T_LOAD:  w = {im[11:0], s1, f3, d, OP_LOAD};
      T_IALU: begin
        // Shift-immediates carry funct7 in the upper bits and a 5-bit shamt.
        if ((f3 == 3'b001) || (f3 == 3'b101)) begin
          w = {f7, im[4:0], s1, f3, d, OP_IALU};
        end else begin
          w = {im[11:0], s1, f3, d, OP_IALU};
        end
      end
      T_S:     w = {im[11:5], s2, s1, f3, im[4:0], OP_S};
      T_B:     w = {im[12], im[10:5], s2, s1, f3, im[4:1], im[11], OP_B};
      T_AUIPC: w = {im[31:12], d, OP_AUIPC};
      T_LUI:   w = {im[31:12], d, OP_LUI};
      T_JALR:  w = {im[11:0], s1, 3'b000, d, OP_JALR};
      T_JAL:   w = {im[20], im[10:1], im[11], im[19:12], d, OP_JAL};
      default: w = 32'd0;
    endcase
    return w;
  endfunction

  logic [1:0]  state;
  logic [1:0]  next_state;
  logic        accept;
  logic        xfer;
  logic        legal;
  logic [31:0] enc_word;

  assign in_ready = (state == S_RUN) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign xfer     = out_valid && out_ready;
  assign legal    = (type_sel <= T_JAL);
  assign enc_word = encode_word(type_sel, funct3, funct7, rd, rs1, rs2, imm);

  // Next-state logic for the program sequencing FSM.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          next_state = S_RUN;
        end else begin
          next_state = S_IDLE;
        end
      end
      S_RUN: begin
        // in_last counts even for a dropped (illegal) bundle.
        if (accept && in_last) begin
          next_state = S_DRAIN;
        end else begin
          next_state = S_RUN;
        end
      end
      S_DRAIN: begin
        if (!out_valid || out_ready) begin
          next_state = S_DONE;
        end else begin
          next_state = S_DRAIN;
        end
      end
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // State register and the registered done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      done  <= 1'b0;
    end else begin
      state <= next_state;
      done  <= (next_state == S_DONE);
    end
  end

  // Address counter, word counter and sticky error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_addr  <= BASE_ADDR;
      out_count <= '0;
      err       <= 1'b0;
    end else if ((state == S_IDLE) && start) begin
      out_addr  <= BASE_ADDR;
      out_count <= '0;
      err       <= 1'b0;
    end else begin
      // out_addr always names the word at the head of the output register,
      // so it steps as each word departs (also when a new one loads).
      if (xfer) begin
        out_addr <= out_addr + ADDR_ONE;
        if (out_count != CNT_MAX) begin
          out_count <= out_count + CNT_ONE;
        end
      end
      if (accept && !legal) begin
        err <= 1'b1;
      end
    end
  end

  // One-entry output register; reload and transfer may coincide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_instr <= 32'd0;
      out_last  <= 1'b0;
    end else if (accept && legal) begin
      out_valid <= 1'b1;
      out_instr <= enc_word;
      out_last  <= in_last;
    end else if (xfer) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= out_valid;
    end
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Streaming RV32I instruction encoder: the inverse of the main control decoder. It accepts one field bundle per handshake (instruction type, register indices, funct fields, immediate) and packs it into a 32-bit RV32I word in the correct R/I/S/B/U/J layout. It emits each word with an incrementing instruction-memory word address, so testbenches and the boot loader can fill instruction memory without an external assembler. It sits between a program source (bench or UART loader) and the instruction-memory write port.

## Interface

- ADDR_WIDTH, 8, instruction-memory word-address width
- BASE_ADDR, 0, first word address after reset or `start`
- clk  in  1  clock, rising edge
- rst  in  1  reset; asynchronous, active-high
- start  in  1  begin a program; honoured only in IDLE
- in_valid  in  1  field bundle valid
- in_ready  out  1  encoder can accept a bundle
- type_sel  in  4  0 R, 1 I-load, 2 I-ALU, 3 S, 4 B, 5 AUIPC, 6 LUI, 7 JALR, 8 JAL; 9–15 illegal
- funct3  in  3  funct3 field
- funct7  in  7  funct7 field (R, and I-ALU shifts)
- rd, rs1, rs2  in  5 each  register indices
- imm  in  32  immediate, interpreted per type
- in_last  in  1  final bundle of the program
- out_valid  out  1  encoded word valid
- out_ready  in  1  memory side accepts word
- out_instr  out  32  encoded instruction
- out_addr  out  ADDR_WIDTH  word address for out_instr
- out_last  out  1  word is the program's last
- out_count  out  ADDR_WIDTH+1  words emitted since `start`
- done  out  1  one-cycle pulse at program completion
- err  out  1  sticky: an illegal type_sel was received since `start`

## Operation

- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: in_ready=0. On `start`, clear out_count and err, load address=BASE_ADDR, then go to RUN.
  - RUN: in_ready = !out_valid || out_ready. Accepting a bundle with in_last=1 moves to DRAIN.
  - DRAIN: in_ready=0. Move to DONE in the cycle where the output register is empty or transferring.
  - DONE: done=1 for one cycle, then IDLE.
- `start` outside IDLE is ignored.
- Opcodes: R 0110011, I-load 0000011, I-ALU 0010011, S 0100011, B 1100011, AUIPC 0010111, LUI 0110111, JALR 1100111, JAL 1101111.
- Packing (bit 31 first):
  - R: funct7, rs2, rs1, funct3, rd, op.
  - I-load, I-ALU: imm[11:0], rs1, funct3, rd, op.
    - I-ALU with funct3 = 001 or 101 (shifts): [31:25]=funct7, [24:20]=imm[4:0].
  - JALR: I layout with funct3 forced to 000.
  - S: imm[11:5], rs2, rs1, funct3, imm[4:0], op.
  - B: imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op. imm[0] is ignored.
  - AUIPC, LUI: imm[31:12], rd, op.
  - JAL: imm[20], imm[10:1], imm[11], imm[19:12], rd, op. imm[0] is ignored.
  - Unused input fields are ignored.
- Illegal type_sel: the bundle is accepted and dropped (no output word), and err is set. Its in_last is still honoured (go to DRAIN).
- Address counter:
  - Increments on each output transfer (out_valid && out_ready).
  - Wraps modulo 2^ADDR_WIDTH.
  - out_count saturates at 2^(ADDR_WIDTH+1)-1.

## Timing

- Reset values: state IDLE, in_ready=0, out_valid=0, out_instr=0, out_addr=BASE_ADDR, out_last=0, out_count=0, done=0, err=0.
- Latency: one cycle from bundle acceptance to out_valid.
- Throughput: one word per cycle while out_ready=1.
- Output register:
  - out_instr, out_addr and out_last hold stable while out_valid && !out_ready.
  - out_valid stays high until the transfer.
- Simultaneous accept and transfer: the register reloads in the same cycle with no bubble. The address advances for the departing word.
- rst mid-program: asynchronous clear to reset values. Any held word is discarded.

## Test plan

- start; type 0, funct7=0, rs2=2, rs1=1, funct3=0, rd=3 -> out_instr 0x002081B3, out_addr 0, out_valid one cycle after accept.
- Type 2, imm=0xFFFFFFFF, rs1=0, rd=5, funct3=0 -> 0xFFF00293. Then type 3, imm=8, rs2=2, rs1=1, funct3=2 -> 0x0020A423 at out_addr 1.
- Type 4, imm=0xFFFFFFFC, rs1=rs2=0, funct3=0 -> 0xFE000EE3. Type 8, imm=0x800, rd=1 -> 0x001000EF. Type 6, imm=0x12345000, rd=10 -> 0x12345537.
- Hold out_ready=0 for 3 cycles with a word pending -> in_ready=0 and output fields constant. Release -> back-to-back words with no bubble, addresses consecutive.
- ADDR_WIDTH=2: emit 5 words, last with in_last=1 -> addresses 0,1,2,3,0; out_count=5; done pulses exactly once after the final transfer; then IDLE with in_ready=0.
- type_sel=12 with in_last=1 -> no out_valid, err=1, out_count unchanged, done pulses. A following start clears err. Assert rst while out_valid=1 -> all outputs at reset values immediately.
